// File: rtl/piano_video_pkg.sv
// Shared constants and types for the falling-note video path.
// Lane geometry and colours are fixed at elaboration time.
package piano_video_pkg;

    localparam int ACTIVE_H_PIXELS = 1280;
    localparam int ACTIVE_LINES    = 720;
    localparam int NUM_LANES       = 8;
    localparam int LANE_WIDTH      = ACTIVE_H_PIXELS / NUM_LANES;
    localparam int MAX_NOTES       = 16;
    localparam int NOTE_HEIGHT     = 48;
    localparam int SPEED           = 4;
    localparam int MAX_Y           = ACTIVE_LINES + NOTE_HEIGHT;

    localparam int LANE_W = $clog2(NUM_LANES);
    localparam int SLOT_W = $clog2(MAX_NOTES);
    localparam int CNT_W  = $clog2(MAX_NOTES + 1);
    localparam int Y_W    = 11;

    typedef logic [23:0] rgb_t;
    typedef logic [10:0] hpos_t;

    localparam rgb_t LANE_COLOR [NUM_LANES] = '{
        24'hFF4040, 24'hFF9F40, 24'hFFFF40, 24'h40FF40,
        24'h40FFFF, 24'h4080FF, 24'hA040FF, 24'hFF40C0
    };

    localparam rgb_t DIVIDER_COLOR = 24'h404040;

    // Inclusive note column span per lane, leaving a 2-pixel gutter.
    localparam hpos_t LANE_LEFT [NUM_LANES] = '{
        11'd2,   11'd162, 11'd322, 11'd482,
        11'd642, 11'd802, 11'd962, 11'd1122
    };

    localparam hpos_t LANE_RIGHT [NUM_LANES] = '{
        11'd157, 11'd317, 11'd477,  11'd637,
        11'd797, 11'd957, 11'd1117, 11'd1277
    };

    typedef struct packed {
        logic              valid;
        logic [LANE_W-1:0] lane;
        logic [Y_W-1:0]    y;
    } note_slot_t;

endpackage

// File: rtl/falling_note_renderer_if.sv
// Spawn handshake between the song sequencer and the note renderer.
// The sequencer is the master; the renderer is the slave.
interface falling_note_renderer_if;
    import piano_video_pkg::*;

    logic              spawn_valid_in;
    logic [LANE_W-1:0] spawn_lane_in;
    logic              spawn_ready_out;

    modport master (
        output spawn_valid_in,
        output spawn_lane_in,
        input  spawn_ready_out
    );

    modport slave (
        input  spawn_valid_in,
        input  spawn_lane_in,
        output spawn_ready_out
    );

endinterface

// File: rtl/falling_note_renderer_note_slot_table.sv
// Note slot table: spawn accept, per-frame fall, expiry and occupancy.
// Frame update and spawn never coincide since spawns are refused on nf.
module note_slot_table
    import piano_video_pkg::*;
(
    input  logic                          pixel_clk_in,
    input  logic                          rst_in,
    input  logic                          nf_in,
    falling_note_renderer_if.slave        spawn,
    output note_slot_t [MAX_NOTES-1:0]    slots_out,
    output logic                          miss_out,
    output logic [CNT_W-1:0]              active_count_out
);

    note_slot_t [MAX_NOTES-1:0] slots_q;
    note_slot_t [MAX_NOTES-1:0] slots_d;
    logic                       free_any;
    logic [SLOT_W-1:0]          free_idx;
    logic                       ready;
    logic                       accept;
    logic                       expire_any;
    logic [CNT_W-1:0]           count_d;

    // Priority encoder: lowest-index free slot.
    always_comb begin
        free_any = 1'b0;
        free_idx = '0;
        for (int i = MAX_NOTES - 1; i >= 0; i--) begin
            if (!slots_q[i].valid) begin
                free_any = 1'b1;
                free_idx = SLOT_W'(i);
            end
        end
    end

    assign ready  = ~rst_in & free_any & ~nf_in;
    assign accept = spawn.spawn_valid_in & ready;
    assign spawn.spawn_ready_out = ready;

    // Next table: fall or expire on nf, load new note on accept.
    always_comb begin
        slots_d    = slots_q;
        expire_any = 1'b0;
        count_d    = '0;
        for (int i = 0; i < MAX_NOTES; i++) begin
            if (nf_in && slots_q[i].valid) begin
                if (slots_q[i].y + Y_W'(SPEED) >= Y_W'(MAX_Y)) begin
                    slots_d[i] = '0;
                    expire_any = 1'b1;
                end else begin
                    slots_d[i].y = slots_q[i].y + Y_W'(SPEED);
                end
            end
            if (accept && free_idx == SLOT_W'(i)) begin
                slots_d[i].valid = 1'b1;
                slots_d[i].lane  = spawn.spawn_lane_in;
                slots_d[i].y     = '0;
            end
            count_d = count_d + CNT_W'(slots_d[i].valid);
        end
    end

    // Table, miss pulse and occupancy registers.
    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            slots_q          <= '0;
            miss_out         <= 1'b0;
            active_count_out <= '0;
        end else begin
            slots_q          <= slots_d;
            miss_out         <= expire_any;
            active_count_out <= count_d;
        end
    end

    assign slots_out = slots_q;

endmodule

// File: rtl/falling_note_renderer.sv
// Falling-note renderer: slot table plus a 2-stage pixel pipeline.
// Syncs travel through the same two registers as the colour.
module falling_note_renderer
    import piano_video_pkg::*;
(
    input  logic                   pixel_clk_in,
    input  logic                   rst_in,
    input  logic [10:0]            hcount_in,
    input  logic [9:0]             vcount_in,
    input  logic                   hs_in,
    input  logic                   vs_in,
    input  logic                   ad_in,
    input  logic                   nf_in,
    falling_note_renderer_if.slave spawn,
    output logic [7:0]             red_out,
    output logic [7:0]             green_out,
    output logic [7:0]             blue_out,
    output logic                   hs_out,
    output logic                   vs_out,
    output logic                   ad_out,
    output logic                   miss_out,
    output logic [CNT_W-1:0]       active_count_out
);

    note_slot_t [MAX_NOTES-1:0] slots;

    note_slot_table u_table (
        .pixel_clk_in     (pixel_clk_in),
        .rst_in           (rst_in),
        .nf_in            (nf_in),
        .spawn            (spawn),
        .slots_out        (slots),
        .miss_out         (miss_out),
        .active_count_out (active_count_out)
    );

    logic [Y_W-1:0]    vpos;
    logic              hit_d;
    logic [LANE_W-1:0] lane_d;
    logic              div_d;
    logic              hit_q;
    logic [LANE_W-1:0] lane_q;
    logic              div_q;
    logic              hs_q;
    logic              vs_q;
    logic              ad_q;
    rgb_t              rgb_d;
    rgb_t              rgb_q;

    assign vpos = {1'b0, vcount_in};

    // Stage 1 hit test; the lowest-index hitting slot picks the lane.
    always_comb begin
        hit_d  = 1'b0;
        lane_d = '0;
        div_d  = 1'b0;
        for (int i = MAX_NOTES - 1; i >= 0; i--) begin
            if (slots[i].valid &&
                hcount_in >= LANE_LEFT[slots[i].lane] &&
                hcount_in <= LANE_RIGHT[slots[i].lane] &&
                vpos < slots[i].y &&
                vpos + Y_W'(NOTE_HEIGHT) >= slots[i].y) begin
                hit_d  = 1'b1;
                lane_d = slots[i].lane;
            end
        end
        for (int l = 0; l < NUM_LANES; l++) begin
            if (hcount_in == LANE_LEFT[l] - 11'd2) begin
                div_d = 1'b1;
            end
        end
    end

    // Stage 2 colour select.
    always_comb begin
        rgb_d = '0;
        if (ad_q) begin
            if (hit_q) begin
                rgb_d = LANE_COLOR[lane_q];
            end else if (div_q) begin
                rgb_d = DIVIDER_COLOR;
            end
        end
    end

    // Pipeline registers for hit info, colour and syncs.
    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            hit_q  <= 1'b0;
            lane_q <= '0;
            div_q  <= 1'b0;
            hs_q   <= 1'b0;
            vs_q   <= 1'b0;
            ad_q   <= 1'b0;
            rgb_q  <= '0;
            hs_out <= 1'b0;
            vs_out <= 1'b0;
            ad_out <= 1'b0;
        end else begin
            hit_q  <= hit_d;
            lane_q <= lane_d;
            div_q  <= div_d;
            hs_q   <= hs_in;
            vs_q   <= vs_in;
            ad_q   <= ad_in;
            rgb_q  <= rgb_d;
            hs_out <= hs_q;
            vs_out <= vs_q;
            ad_out <= ad_q;
        end
    end

    assign red_out   = rgb_q[23:16];
    assign green_out = rgb_q[15:8];
    assign blue_out  = rgb_q[7:0];

endmodule
